// File: rtl/fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter
//
// Purpose:
//   Shares one multi-cycle, single-port memory between the instruction-fetch
//   requester (read-only) and the data-memory requester (read/write). The data
//   side wins arbitration, except when it has already taken MAX_D_STREAK grants
//   in a row while fetch was waiting. Generates per-requester done/stall so the
//   PC and the pipeline freeze while their access is outstanding.
//
// Ports:
//   clk, rst            clock (rising edge) / asynchronous active-low reset
//   i_req/i_addr        fetch request and PC; request held until i_done/i_flush
//   i_flush             abandon the outstanding fetch (branch taken)
//   i_rdata/i_done      fetched instruction, valid with the 1-cycle i_done
//   i_stall             fetch pending: freeze the PC
//   d_req/d_wr          data request and direction (1 = write)
//   d_addr/d_wdata      data address / store data
//   d_rdata/d_done      load data (0 for writes), valid with 1-cycle d_done
//   d_stall             data access pending: freeze the pipeline
//   err                 1-cycle pulse: unaligned address rejected
//   mem_rd/mem_wr       memory strobes, held until mem_done
//   mem_addr/mem_wdata  memory command, held until mem_done
//   mem_rdata/mem_done  memory read data and completion pulse
//   o_dbg_state         current FSM state (IDLE/BUSY_I/BUSY_D)
//
// Handshake: a requester raises x_req with its command and holds both stable
// until x_done is seen high (fetch may also withdraw with i_flush). x_done is a
// single-cycle pulse and is the only acknowledgement; the memory side holds its
// strobe and command stable until mem_done, which is likewise a 1-cycle pulse.
// -----------------------------------------------------------------------------
module fetch_mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_D_STREAK);

  state_t      r_state;
  logic [3:0]  r_streak;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_i_rdata;
  logic [15:0] r_d_rdata;
  logic        r_err;
  logic        r_i_udone;
  logic        r_d_udone;
  logic        r_flush;

  logic        w_idle;
  logic        w_d_win;
  logic        w_i_win;
  logic        w_i_fin;
  logic        w_d_fin;
  logic        w_i_done;
  logic        w_d_done;
  logic [3:0]  w_streak_inc;

  // While an unaligned-reject pulse is out, the rejected requester still holds
  // its request for that one cycle, so no grant is made then.
  assign w_idle  = (r_state == S_IDLE) && !r_err;
  assign w_d_win = w_idle && d_req && (!i_req || (r_streak < LP_MAX));
  assign w_i_win = w_idle && !w_d_win && i_req && !i_flush;

  // A flush seen during the access, or in its completion cycle, swallows done.
  assign w_i_fin = (r_state == S_BUSY_I) && mem_done && !r_flush && !i_flush;
  assign w_d_fin = (r_state == S_BUSY_D) && mem_done;

  assign w_streak_inc = (r_streak < LP_MAX) ? (r_streak + 4'd1) : r_streak;

  assign w_i_done = w_i_fin || r_i_udone;
  assign w_d_done = w_d_fin || r_d_udone;

  assign i_done      = w_i_done;
  assign d_done      = w_d_done;
  assign i_stall     = i_req && !w_i_done;
  assign d_stall     = d_req && !w_d_done;
  assign err         = r_err;
  assign i_rdata     = w_i_fin ? mem_rdata : r_i_rdata;
  assign d_rdata     = w_d_fin ? (r_mem_wr ? 16'h0 : mem_rdata) : r_d_rdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_streak    <= 4'd0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0;
      r_mem_wdata <= 16'h0;
      r_i_rdata   <= 16'h0;
      r_d_rdata   <= 16'h0;
      r_err       <= 1'b0;
      r_i_udone   <= 1'b0;
      r_d_udone   <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_i_udone <= 1'b0;
      r_d_udone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win) begin
            // Streak only counts grants taken while fetch is actually waiting.
            r_streak <= i_req ? w_streak_inc : 4'd0;
            if (d_addr[0]) begin
              r_err     <= 1'b1;
              r_d_udone <= 1'b1;
              r_d_rdata <= 16'h0;
            end else begin
              r_state     <= S_BUSY_D;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_rd    <= !d_wr;
              r_mem_wr    <= d_wr;
            end
          end else if (w_i_win) begin
            r_streak <= 4'd0;
            if (i_addr[0]) begin
              r_err     <= 1'b1;
              r_i_udone <= 1'b1;
              r_i_rdata <= 16'h0;
            end else begin
              r_state    <= S_BUSY_I;
              r_mem_addr <= i_addr;
              r_mem_rd   <= 1'b1;
              r_mem_wr   <= 1'b0;
            end
          end
        end
        S_BUSY_I: begin
          // The memory cannot abort, so a flush only marks the result as dead.
          if (i_flush) begin
            r_flush <= 1'b1;
          end
          if (mem_done) begin
            r_state  <= S_IDLE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_flush  <= 1'b0;
            if (w_i_fin) begin
              r_i_rdata <= mem_rdata;
            end
          end
        end
        S_BUSY_D: begin
          if (mem_done) begin
            r_state   <= S_IDLE;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_d_rdata <= r_mem_wr ? 16'h0 : mem_rdata;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
